dff_char_seq: RTL and testbench

- Measurement sequencer for the DFF characterization tile array.
- Selects one tile at a time and drives the shared D/CLK stimulus with a programmable D-to-CLK skew in clock cycles.
- After each capture, walks all 8 DUT flops of that tile through the tile output mux, samples the observed Q and reports pass/fail per flop.
- Sits between the test-control register block and the N_TILE tile instances.

---
 rtl/dff_char_pkg.sv | 27 ++
 rtl/dff_char_sync2.sv | 22 ++
 rtl/dff_char_seq.sv | 256 +++++++++++++++++++++++++
 tb/tb_dff_char_seq.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dff_char_pkg.sv
// Shared types and constants for the DFF characterization sequencer.
// Holds the sequencer state enum, the tile signal-select codes and the
// number of DUT flops per tile.
package dff_char_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_SEL,
        ST_INIT_HI,
        ST_INIT_LO,
        ST_LAUNCH,
        ST_CAPT_HI,
        ST_CAPT_LO,
        ST_OBS_WAIT,
        ST_OBS_SMP,
        ST_DONE
    } state_e;

    // Tile output mux signal selects
    localparam logic [1:0] SIG_D   = 2'd0;
    localparam logic [1:0] SIG_CLK = 2'd1;
    localparam logic [1:0] SIG_Q0  = 2'd2;
    localparam logic [1:0] SIG_Q1  = 2'd3;

    localparam int unsigned DUTS_PER_TILE = 8;

endpackage

// File: rtl/dff_char_sync2.sv
// Two-flop synchronizer for the asynchronous tile mux return.
// Ports: clk, rst_n (async active-low, resets to 0), d (async in), q (synced out).
module dff_char_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/dff_char_seq.sv
// Measurement sequencer for the DFF characterization tile array.
// Walks the tiles one at a time: presets all DUT flops to ~d_val, launches
// d_val, clocks it in after a programmable skew, then reads back each of the
// 8 DUT Q outputs through the tile mux and reports pass/fail per flop.
// Ports:
//   i_clk, i_rstn (async active-low), i_start, i_abort, i_d_val, i_skew,
//   i_mux (async tile return); o_sel_tile/o_sel_dut/o_sel_sig (tile selects),
//   o_d/o_dut_clk (stimulus), o_busy, o_done, o_res_* (result strobe+payload).
// Optional: define DFF_CHAR_ERRCNT_EN to add o_err_cnt, a per-sweep fail count.
module dff_char_seq
    import dff_char_pkg::*;
#(
    parameter int unsigned N_TILE     = 4,
    parameter int unsigned SETTLE_CYC = 8,
    parameter int unsigned SKEW_W     = 8
) (
    input  logic                        i_clk,
    input  logic                        i_rstn,
    input  logic                        i_start,
    input  logic                        i_abort,
    input  logic                        i_d_val,
    input  logic [SKEW_W-1:0]           i_skew,
    input  logic                        i_mux,
    output logic [N_TILE-1:0]           o_sel_tile,
    output logic [1:0]                  o_sel_dut,
    output logic [1:0]                  o_sel_sig,
    output logic                        o_d,
    output logic                        o_dut_clk,
    output logic                        o_busy,
    output logic                        o_done,
    output logic                        o_res_valid,
    output logic [$clog2(N_TILE)-1:0]   o_res_tile,
    output logic [2:0]                  o_res_dut,
    output logic                        o_res_q,
    output logic                        o_res_pass
`ifdef DFF_CHAR_ERRCNT_EN
    ,
    output logic [$clog2(8*N_TILE+1)-1:0] o_err_cnt
`endif
);

    localparam int unsigned      TILE_W    = $clog2(N_TILE);
    localparam logic [7:0]       SETTLE_M1 = 8'(SETTLE_CYC - 1);
    localparam logic [TILE_W-1:0] TILE_LAST = TILE_W'(N_TILE - 1);
    localparam logic [2:0]       DUT_LAST  = 3'(DUTS_PER_TILE - 1);
    localparam logic [N_TILE-1:0] TILE_ONE = N_TILE'(1);

    state_e              state, state_nxt;
    logic [7:0]          wait_cnt, wait_nxt;
    logic [SKEW_W-1:0]   skew_cnt, skew_cnt_nxt;
    logic [SKEW_W-1:0]   skew_lat, skew_lat_nxt;
    logic                d_val, d_val_nxt;
    logic [TILE_W-1:0]   tile, tile_nxt;
    logic [2:0]          dut, dut_nxt;
    logic                mux_sync;

    logic [N_TILE-1:0]   sel_tile_nxt;
    logic [1:0]          sel_dut_nxt, sel_sig_nxt;
    logic                d_nxt, dut_clk_nxt, busy_nxt, done_nxt;
    logic                res_valid_nxt, res_q_nxt, res_pass_nxt;
    logic [TILE_W-1:0]   res_tile_nxt;
    logic [2:0]          res_dut_nxt;
`ifdef DFF_CHAR_ERRCNT_EN
    logic [$clog2(8*N_TILE+1)-1:0] err_nxt;
`endif

    // Tile mux return is asynchronous to i_clk
    dff_char_sync2 u_sync (
        .clk   (i_clk),
        .rst_n (i_rstn),
        .d     (i_mux),
        .q     (mux_sync)
    );

    // State, counters and all outputs registered together
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state       <= ST_IDLE;
            wait_cnt    <= '0;
            skew_cnt    <= '0;
            skew_lat    <= '0;
            d_val       <= 1'b0;
            tile        <= '0;
            dut         <= '0;
            o_sel_tile  <= '0;
            o_sel_dut   <= '0;
            o_sel_sig   <= '0;
            o_d         <= 1'b0;
            o_dut_clk   <= 1'b0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
            o_res_valid <= 1'b0;
            o_res_tile  <= '0;
            o_res_dut   <= '0;
            o_res_q     <= 1'b0;
            o_res_pass  <= 1'b0;
`ifdef DFF_CHAR_ERRCNT_EN
            o_err_cnt   <= '0;
`endif
        end else begin
            state       <= state_nxt;
            wait_cnt    <= wait_nxt;
            skew_cnt    <= skew_cnt_nxt;
            skew_lat    <= skew_lat_nxt;
            d_val       <= d_val_nxt;
            tile        <= tile_nxt;
            dut         <= dut_nxt;
            o_sel_tile  <= sel_tile_nxt;
            o_sel_dut   <= sel_dut_nxt;
            o_sel_sig   <= sel_sig_nxt;
            o_d         <= d_nxt;
            o_dut_clk   <= dut_clk_nxt;
            o_busy      <= busy_nxt;
            o_done      <= done_nxt;
            o_res_valid <= res_valid_nxt;
            o_res_tile  <= res_tile_nxt;
            o_res_dut   <= res_dut_nxt;
            o_res_q     <= res_q_nxt;
            o_res_pass  <= res_pass_nxt;
`ifdef DFF_CHAR_ERRCNT_EN
            o_err_cnt   <= err_nxt;
`endif
        end
    end

    // Next state, counters and next output values
    always_comb begin
        state_nxt     = state;
        wait_nxt      = wait_cnt;
        skew_cnt_nxt  = skew_cnt;
        skew_lat_nxt  = skew_lat;
        d_val_nxt     = d_val;
        tile_nxt      = tile;
        dut_nxt       = dut;
        res_valid_nxt = 1'b0;
        res_tile_nxt  = o_res_tile;
        res_dut_nxt   = o_res_dut;
        res_q_nxt     = o_res_q;
        res_pass_nxt  = o_res_pass;
`ifdef DFF_CHAR_ERRCNT_EN
        err_nxt       = o_err_cnt;
`endif

        case (state)
            ST_IDLE: begin
                if (i_start && !i_abort) begin
                    d_val_nxt    = i_d_val;
                    skew_lat_nxt = i_skew;
                    tile_nxt     = '0;
                    dut_nxt      = '0;
                    wait_nxt     = SETTLE_M1;
                    state_nxt    = ST_SEL;
`ifdef DFF_CHAR_ERRCNT_EN
                    err_nxt      = '0;
`endif
                end
            end
            ST_SEL, ST_INIT_HI, ST_CAPT_HI: begin
                if (wait_cnt == 8'd0) begin
                    wait_nxt  = SETTLE_M1;
                    state_nxt = (state == ST_SEL)     ? ST_INIT_HI :
                                (state == ST_INIT_HI) ? ST_INIT_LO : ST_CAPT_LO;
                end else begin
                    wait_nxt = wait_cnt - 8'd1;
                end
            end
            ST_INIT_LO: begin
                if (wait_cnt != 8'd0) begin
                    wait_nxt = wait_cnt - 8'd1;
                end else if (skew_lat == '0) begin
                    // Zero skew: D and CLK change on the same edge
                    wait_nxt  = SETTLE_M1;
                    state_nxt = ST_CAPT_HI;
                end else begin
                    skew_cnt_nxt = skew_lat - SKEW_W'(1);
                    state_nxt    = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                if (skew_cnt == '0) begin
                    wait_nxt  = SETTLE_M1;
                    state_nxt = ST_CAPT_HI;
                end else begin
                    skew_cnt_nxt = skew_cnt - SKEW_W'(1);
                end
            end
            ST_CAPT_LO: begin
                if (wait_cnt == 8'd0) begin
                    wait_nxt  = SETTLE_M1;
                    dut_nxt   = '0;
                    state_nxt = ST_OBS_WAIT;
                end else begin
                    wait_nxt = wait_cnt - 8'd1;
                end
            end
            ST_OBS_WAIT: begin
                if (wait_cnt == 8'd0) begin
                    res_valid_nxt = 1'b1;
                    res_tile_nxt  = tile;
                    res_dut_nxt   = dut;
                    res_q_nxt     = mux_sync;
                    res_pass_nxt  = (mux_sync == d_val);
                    state_nxt     = ST_OBS_SMP;
                end else begin
                    wait_nxt = wait_cnt - 8'd1;
                end
            end
            ST_OBS_SMP: begin
                wait_nxt = SETTLE_M1;
                if (dut != DUT_LAST) begin
                    dut_nxt   = dut + 3'd1;
                    state_nxt = ST_OBS_WAIT;
                end else if (tile != TILE_LAST) begin
                    tile_nxt  = tile + TILE_W'(1);
                    state_nxt = ST_SEL;
                end else begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase

        // Abort from any busy state overrides everything, including a pending strobe
        if (i_abort && state != ST_IDLE && state != ST_DONE) begin
            state_nxt     = ST_IDLE;
            res_valid_nxt = 1'b0;
        end

`ifdef DFF_CHAR_ERRCNT_EN
        if (res_valid_nxt && !res_pass_nxt) begin
            err_nxt = o_err_cnt + ($clog2(8*N_TILE+1))'(1);
        end
`endif

        // Outputs decoded from the state being entered
        busy_nxt     = (state_nxt != ST_IDLE) && (state_nxt != ST_DONE);
        done_nxt     = (state_nxt == ST_DONE);
        sel_tile_nxt = busy_nxt ? (TILE_ONE << tile_nxt) : '0;
        dut_clk_nxt  = (state_nxt == ST_INIT_HI) || (state_nxt == ST_CAPT_HI);
        sel_dut_nxt  = '0;
        sel_sig_nxt  = SIG_D;
        d_nxt        = 1'b0;
        case (state_nxt)
            ST_SEL, ST_INIT_HI, ST_INIT_LO: d_nxt = ~d_val_nxt;
            ST_LAUNCH, ST_CAPT_HI, ST_CAPT_LO: d_nxt = d_val_nxt;
            ST_OBS_WAIT, ST_OBS_SMP: begin
                d_nxt       = d_val_nxt;
                sel_dut_nxt = dut_nxt[2:1];
                sel_sig_nxt = dut_nxt[0] ? SIG_Q1 : SIG_Q0;
            end
            default: d_nxt = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_dff_char_seq.sv
// Directed bench for dff_char_seq with a behavioural tile-array model.
module tb_dff_char_seq;

    localparam int unsigned N_TILE = 4;
    localparam int unsigned SETTLE = 4;
    localparam int unsigned SKEW_W = 8;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic              d_val = 1'b0;
    logic [SKEW_W-1:0] skew = '0;
    logic              mux_c;

    logic [N_TILE-1:0] o_sel_tile;
    logic [1:0]        o_sel_dut, o_sel_sig;
    logic              o_d, o_dut_clk, o_busy, o_done;
    logic              o_res_valid, o_res_q, o_res_pass;
    logic [1:0]        o_res_tile;
    logic [2:0]        o_res_dut;
`ifdef DFF_CHAR_ERRCNT_EN
    logic [5:0]        o_err_cnt;
`endif

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        int   tile;
        int   dut;
        logic q;
        logic pass;
    } res_t;
    res_t res_q[$];
    int   busy_cyc = 0;
    int   done_cnt = 0;

    // Tile array model
    logic q_mdl [N_TILE][8];
    bit   stuck_en = 0;
    int   stuck_t = 0, stuck_d = 0;

    dff_char_seq #(
        .N_TILE     (N_TILE),
        .SETTLE_CYC (SETTLE),
        .SKEW_W     (SKEW_W)
    ) dut_i (
        .i_clk       (clk),
        .i_rstn      (rstn),
        .i_start     (start),
        .i_abort     (abort),
        .i_d_val     (d_val),
        .i_skew      (skew),
        .i_mux       (mux_c),
        .o_sel_tile  (o_sel_tile),
        .o_sel_dut   (o_sel_dut),
        .o_sel_sig   (o_sel_sig),
        .o_d         (o_d),
        .o_dut_clk   (o_dut_clk),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_res_valid (o_res_valid),
        .o_res_tile  (o_res_tile),
        .o_res_dut   (o_res_dut),
        .o_res_q     (o_res_q),
        .o_res_pass  (o_res_pass)
`ifdef DFF_CHAR_ERRCNT_EN
        ,
        .o_err_cnt   (o_err_cnt)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        for (int t = 0; t < N_TILE; t++)
            for (int k = 0; k < 8; k++)
                q_mdl[t][k] = 1'b0;
    end

    // Selected tile's DUT flops capture o_d on the rising stimulus clock
    always @(posedge o_dut_clk) begin
        #1;
        for (int t = 0; t < N_TILE; t++)
            if (o_sel_tile[t])
                for (int k = 0; k < 8; k++)
                    q_mdl[t][k] = (stuck_en && t == stuck_t && k == stuck_d) ? 1'b0 : o_d;
    end

    always_comb begin
        mux_c = 1'b0;
        for (int t = 0; t < N_TILE; t++)
            if (o_sel_tile[t])
                case (o_sel_sig)
                    2'd0:    mux_c = o_d;
                    2'd1:    mux_c = o_dut_clk;
                    2'd2:    mux_c = q_mdl[t][int'(o_sel_dut) * 2];
                    default: mux_c = q_mdl[t][int'(o_sel_dut) * 2 + 1];
                endcase
    end

    // Result / busy / done monitor
    always @(negedge clk) begin
        if (o_res_valid) res_q.push_back('{int'(o_res_tile), int'(o_res_dut), o_res_q, o_res_pass});
        if (o_busy) busy_cyc++;
        if (o_done) done_cnt++;
    end

    task automatic start_sweep(input logic d, input logic [SKEW_W-1:0] sk);
        @(negedge clk);
        res_q.delete();
        busy_cyc = 0;
        done_cnt = 0;
        d_val = d;
        skew  = sk;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        d_val = ~d;
        skew  = '0;
    endtask

    task automatic wait_done(input int max_cyc, output bit ok);
        ok = 0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (o_done) begin
                ok = 1;
                break;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset;
        rstn = 1'b0;
        #1;
        n_vec++;
        if ({o_sel_tile, o_sel_dut, o_sel_sig, o_d, o_dut_clk, o_busy, o_done,
             o_res_valid, o_res_tile, o_res_dut, o_res_q, o_res_pass} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got sel_tile=%b busy=%b d=%b clk=%b want all 0",
                     o_sel_tile, o_busy, o_d, o_dut_clk);
        end
`ifdef DFF_CHAR_ERRCNT_EN
        n_vec++;
        if (o_err_cnt !== 6'd0) begin
            n_err++;
            $display("FAIL reset_err_cnt: got %0d want 0", o_err_cnt);
        end
`endif
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        repeat (2) @(negedge clk);
        n_vec++;
        if (o_busy !== 1'b0 || o_sel_tile !== '0) begin
            n_err++;
            $display("FAIL idle_after_reset: got busy=%b sel_tile=%b want 0 0", o_busy, o_sel_tile);
        end
    endtask

    task automatic test_full_sweep;
        bit ok;
        start_sweep(1'b1, 8'd3);
        repeat (50) @(negedge clk);
        start = 1'b1;   // ignored while busy
        @(negedge clk);
        start = 1'b0;
        wait_done(2000, ok);
        n_vec++;
        if (!ok) begin n_err++; $display("FAIL full_done_timeout: got no o_done want o_done"); end
        n_vec++;
        if (res_q.size() != 32) begin
            n_err++; $display("FAIL full_count: got %0d want 32", res_q.size());
        end
        for (int i = 0; i < res_q.size(); i++) begin
            n_vec++;
            if (res_q[i].tile != i / 8 || res_q[i].dut != i % 8 || res_q[i].q !== 1'b1 || res_q[i].pass !== 1'b1) begin
                n_err++;
                $display("FAIL full_result[%0d]: got t%0d d%0d q%b p%b want t%0d d%0d q1 p1",
                         i, res_q[i].tile, res_q[i].dut, res_q[i].q, res_q[i].pass, i / 8, i % 8);
            end
        end
        n_vec++;
        if (done_cnt != 1) begin n_err++; $display("FAIL full_done_cnt: got %0d want 1", done_cnt); end
        n_vec++;
        if (busy_cyc != 252) begin n_err++; $display("FAIL full_busy_cyc: got %0d want 252", busy_cyc); end
`ifdef DFF_CHAR_ERRCNT_EN
        n_vec++;
        if (o_err_cnt !== 6'd0) begin n_err++; $display("FAIL full_err_cnt: got %0d want 0", o_err_cnt); end
`endif
    endtask

    task automatic test_skew(input int sk);
        int  d_rise, c_rise, rises;
        logic prev_clk;
        d_rise = -1; c_rise = -1; rises = 0; prev_clk = 1'b0;
        start_sweep(1'b1, SKEW_W'(sk));
        for (int i = 0; i < 40; i++) begin
            if (i > 0) @(negedge clk);
            if (o_d === 1'b1 && d_rise < 0) d_rise = i;
            if (o_dut_clk === 1'b1 && prev_clk === 1'b0) begin
                rises++;
                if (rises == 2) c_rise = i;
            end
            prev_clk = o_dut_clk;
        end
        n_vec++;
        if (d_rise != 12) begin n_err++; $display("FAIL skew%0d_d_rise: got %0d want 12", sk, d_rise); end
        n_vec++;
        if (c_rise != 12 + sk) begin n_err++; $display("FAIL skew%0d_clk_rise: got %0d want %0d", sk, c_rise, 12 + sk); end
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        n_vec++;
        if (o_busy !== 1'b0) begin n_err++; $display("FAIL skew%0d_abort_busy: got %b want 0", sk, o_busy); end
    endtask

    task automatic test_fail_report;
        bit ok;
        int nfail;
        stuck_en = 1; stuck_t = 2; stuck_d = 5;
        start_sweep(1'b1, 8'd3);
        wait_done(2000, ok);
        stuck_en = 0;
        n_vec++;
        if (!ok || res_q.size() != 32) begin
            n_err++; $display("FAIL fail_sweep: got done=%0d count=%0d want 1 32", ok, res_q.size());
        end
        nfail = 0;
        foreach (res_q[i]) if (res_q[i].pass !== 1'b1) nfail++;
        n_vec++;
        if (nfail != 1) begin n_err++; $display("FAIL fail_count: got %0d want 1", nfail); end
        if (res_q.size() > 21) begin
            n_vec++;
            if (res_q[21].tile != 2 || res_q[21].dut != 5 || res_q[21].q !== 1'b0 || res_q[21].pass !== 1'b0) begin
                n_err++;
                $display("FAIL fail_entry: got t%0d d%0d q%b p%b want t2 d5 q0 p0",
                         res_q[21].tile, res_q[21].dut, res_q[21].q, res_q[21].pass);
            end
        end
`ifdef DFF_CHAR_ERRCNT_EN
        n_vec++;
        if (o_err_cnt !== 6'd1) begin n_err++; $display("FAIL fail_err_cnt: got %0d want 1", o_err_cnt); end
`endif
    endtask

    task automatic test_abort;
        bit found, ok;
        found = 0;
        start_sweep(1'b1, 8'd3);
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (o_sel_tile === 4'b0010 && o_sel_sig >= 2'd2 && !o_res_valid) begin
                found = 1;
                break;
            end
        end
        n_vec++;
        if (!found) begin n_err++; $display("FAIL abort_reach_obs: got timeout want tile1 OBS_WAIT"); end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        n_vec++;
        if ({o_busy, o_sel_tile, o_sel_dut, o_sel_sig, o_d, o_dut_clk} !== '0) begin
            n_err++;
            $display("FAIL abort_outputs: got busy=%b tile=%b dut=%b sig=%b d=%b clk=%b want all 0",
                     o_busy, o_sel_tile, o_sel_dut, o_sel_sig, o_d, o_dut_clk);
        end
        repeat (300) @(negedge clk);
        n_vec++;
        if (res_q.size() != 8) begin n_err++; $display("FAIL abort_strobes: got %0d want 8", res_q.size()); end
        n_vec++;
        if (done_cnt != 0) begin n_err++; $display("FAIL abort_done: got %0d want 0", done_cnt); end
`ifdef DFF_CHAR_ERRCNT_EN
        n_vec++;
        if (o_err_cnt !== 6'd0) begin n_err++; $display("FAIL abort_err_cnt: got %0d want 0", o_err_cnt); end
`endif
        start_sweep(1'b0, 8'd1);
        wait_done(2000, ok);
        n_vec++;
        if (!ok || res_q.size() != 32 || done_cnt != 1) begin
            n_err++;
            $display("FAIL abort_resweep: got done=%0d count=%0d done_cnt=%0d want 1 32 1", ok, res_q.size(), done_cnt);
        end
        for (int i = 0; i < res_q.size(); i++) begin
            n_vec++;
            if (res_q[i].tile != i / 8 || res_q[i].dut != i % 8 || res_q[i].q !== 1'b0 || res_q[i].pass !== 1'b1) begin
                n_err++;
                $display("FAIL resweep_result[%0d]: got t%0d d%0d q%b p%b want t%0d d%0d q0 p1",
                         i, res_q[i].tile, res_q[i].dut, res_q[i].q, res_q[i].pass, i / 8, i % 8);
            end
        end
    endtask

    task automatic test_start_abort_idle;
        @(negedge clk);
        res_q.delete();
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        repeat (3) @(negedge clk);
        n_vec++;
        if (o_busy !== 1'b0 || o_sel_tile !== '0) begin
            n_err++; $display("FAIL start_abort_idle: got busy=%b sel_tile=%b want 0 0", o_busy, o_sel_tile);
        end
    endtask

    task automatic test_sel_encoding;
        int  k;
        bit  ok;
        k = 0; ok = 0;
        start_sweep(1'b1, 8'd2);
        for (int i = 0; i < 500; i++) begin
            if (o_busy) begin
                n_vec++;
                if (!$onehot(o_sel_tile)) begin
                    n_err++; $display("FAIL sel_onehot: got %b want one-hot", o_sel_tile);
                end
            end
            if (o_res_valid) begin
                n_vec++;
                if (o_res_dut !== 3'(k % 8) || o_sel_dut !== 2'((k % 8) >> 1) || o_sel_sig !== 2'(2 + (k % 2))) begin
                    n_err++;
                    $display("FAIL sel_encoding[%0d]: got dut=%0d sel_dut=%0d sel_sig=%0d want %0d %0d %0d",
                             k, o_res_dut, o_sel_dut, o_sel_sig, k % 8, (k % 8) >> 1, 2 + (k % 2));
                end
                k++;
                if (k == 12) break;
            end
            @(negedge clk);
        end
        n_vec++;
        if (k != 12) begin n_err++; $display("FAIL sel_strobes: got %0d want 12", k); end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        @(negedge clk);
        n_vec++;
        if (o_sel_tile !== '0) begin n_err++; $display("FAIL sel_idle_tile: got %b want 0", o_sel_tile); end
    endtask

    task automatic test_reset_mid;
        int   rises;
        logic prev_clk;
        bit   hit;
        rises = 0; prev_clk = 1'b0; hit = 0;
        start_sweep(1'b1, 8'd3);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            start = (i == 3);   // pulse while busy: must leave no trace
            if (o_dut_clk === 1'b1 && prev_clk === 1'b0) rises++;
            prev_clk = o_dut_clk;
            if (rises == 2) begin hit = 1; break; end
        end
        start = 1'b0;
        n_vec++;
        if (!hit || o_dut_clk !== 1'b1) begin
            n_err++; $display("FAIL rst_mid_reach: got rises=%0d clk=%b want 2 1", rises, o_dut_clk);
        end
        #2;
        rstn = 1'b0;
        #1;
        n_vec++;
        if (o_dut_clk !== 1'b0) begin n_err++; $display("FAIL rst_mid_clk: got %b want 0", o_dut_clk); end
        n_vec++;
        if ({o_sel_tile, o_sel_dut, o_sel_sig, o_d, o_busy, o_done,
             o_res_valid, o_res_tile, o_res_dut, o_res_q, o_res_pass} !== '0) begin
            n_err++;
            $display("FAIL rst_mid_outputs: got busy=%b sel_tile=%b d=%b want all 0", o_busy, o_sel_tile, o_d);
        end
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        repeat (20) @(negedge clk);
        n_vec++;
        if (o_busy !== 1'b0 || o_sel_tile !== '0 || res_q.size() != 0 || done_cnt != 0) begin
            n_err++;
            $display("FAIL rst_mid_idle: got busy=%b tile=%b strobes=%0d done=%0d want 0 0 0 0",
                     o_busy, o_sel_tile, res_q.size(), done_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_full_sweep();
        test_skew(5);
        test_skew(0);
        test_fail_report();
        test_abort();
        test_start_abort_idle();
        test_sel_encoding();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no completion want completion");
        $fatal(1);
    end

endmodule
